mc_ctrl_fsm: RTL

- Main control unit of the multi-cycle MIPS32 core.
- Sequences the shared datapath (PC, IR, register file, ALU, unified memory) through the fetch, decode, execute, memory and writeback steps.
- Emits per-cycle write strobes and mux selects.
- Sits in Top between the IR fields and the datapath; adds a memory ready handshake so memory may take several cycles.

---
 rtl/mc_ctrl_fsm.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multi-cycle MIPS32 core: sequences fetch, decode,
// execute, memory and writeback over the shared datapath with a memory ready handshake.
module mc_ctrl_fsm #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] func,
  input  logic            zero,
  input  logic            mem_ready,
  output logic [ST_W-1:0] state_out,
  output logic            PCWr,
  output logic            IRWr,
  output logic            RegWr,
  output logic            RegDst,
  output logic            MemtoReg,
  output logic            MemRd,
  output logic            MemWr,
  output logic            IorD,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic            ExtOp,
  output logic [3:0]      ALUOp,
  output logic [1:0]      PCSrc,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [ST_W-1:0] {
    S_IF  = 0,  S_ID  = 1,  S_EXR = 2,  S_WBR = 3,
    S_EXI = 4,  S_WBI = 5,  S_MA  = 6,  S_MRD = 7,
    S_WBL = 8,  S_MWR = 9,  S_BR  = 10, S_HALT = 11,
    S_ILL = 12
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  state_t     state;
  state_t     next_state;
  logic       func_ok;
  logic [3:0] func_aluop;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!reset) state <= S_IF;
    else        state <= next_state;
  end

  always_comb begin
    func_ok    = 1'b1;
    func_aluop = ALU_ADD;
    case (func)
      6'b100000: func_aluop = ALU_ADD;
      6'b100010: func_aluop = ALU_SUB;
      6'b100100: func_aluop = ALU_AND;
      6'b100101: func_aluop = ALU_OR;
      6'b101010: func_aluop = ALU_SLT;
      default:   func_ok    = 1'b0;
    endcase
  end

  // NOTE: every output is given a default before the case so no path can infer a latch.
  always_comb begin
    next_state = state;
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    RegWr    = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    IorD     = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ExtOp    = 1'b1;
    ALUOp    = ALU_ADD;
    PCSrc    = 2'b00;
    halted   = 1'b0;
    illegal  = 1'b0;

    // Reset low leaves every output at its default, which also aborts a pending access.
    if (reset) begin
      case (state)
        S_IF: begin
          MemRd   = 1'b1;
          ALUSrcB = 2'b01;
          IRWr    = mem_ready;
          PCWr    = mem_ready;
          if (mem_ready) next_state = S_ID;
        end
        S_ID: begin
          ALUSrcB = 2'b11;
          case (opcode)
            OP_RTYPE:        next_state = func_ok ? S_EXR : S_ILL;
            OP_ADDI, OP_ORI: next_state = S_EXI;
            OP_LW, OP_SW:    next_state = S_MA;
            OP_BEQ:          next_state = S_BR;
            OP_J: begin
              PCWr       = 1'b1;
              PCSrc      = 2'b10;
              next_state = S_IF;
            end
            OP_HALT:         next_state = S_HALT;
            default:         next_state = S_ILL;
          endcase
        end
        S_EXR: begin
          ALUSrcA    = 1'b1;
          ALUOp      = func_aluop;
          next_state = S_WBR;
        end
        S_WBR: begin
          RegWr      = 1'b1;
          RegDst     = 1'b1;
          next_state = S_IF;
        end
        S_EXI: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          if (opcode == OP_ORI) begin
            ExtOp = 1'b0;
            ALUOp = ALU_OR;
          end
          next_state = S_WBI;
        end
        S_WBI: begin
          RegWr      = 1'b1;
          next_state = S_IF;
        end
        S_MA: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          next_state = (opcode == OP_SW) ? S_MWR : S_MRD;
        end
        S_MRD: begin
          MemRd = 1'b1;
          IorD  = 1'b1;
          if (mem_ready) next_state = S_WBL;
        end
        S_WBL: begin
          RegWr      = 1'b1;
          MemtoReg   = 1'b1;
          next_state = S_IF;
        end
        S_MWR: begin
          MemWr = 1'b1;
          IorD  = 1'b1;
          if (mem_ready) next_state = S_IF;
        end
        S_BR: begin
          ALUSrcA    = 1'b1;
          ALUOp      = ALU_SUB;
          PCSrc      = 2'b01;
          PCWr       = zero;
          next_state = S_IF;
        end
        S_HALT:  halted  = 1'b1;
        S_ILL:   illegal = 1'b1;
        default: next_state = S_IF;
      endcase
    end
  end

  assign state_out = reset ? state : '0;

endmodule
